// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types used by the register file slice.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    // True when the index names the hardwired $zero register.
    function automatic logic is_zero_reg(input reg_idx_t idx);
        return (idx == REG_ZERO);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: $zero check, same-cycle
// write-back bypass and storage mux.
module rf_read_port
    import mips_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NREGS = 32
) (
    input  logic [AW-1:0] read_reg,
    input  logic [DW-1:0] regs [NREGS],
    input  logic          reg_write,
    input  logic [AW-1:0] write_reg,
    input  logic [DW-1:0] write_data,
    input  logic          reset,
    output logic [DW-1:0] read_data
);

    logic bypass_s;

    // Bypass only when WB targets this index; reset suppresses it so reads
    // show stored contents. A nonzero read index also excludes $zero writes.
    always_comb begin
        bypass_s = 1'b0;
        if (reg_write && (write_reg == read_reg) && !reset) begin
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
    end

    // Select zero, the in-flight write-back value, or the stored register.
    always_comb begin
        read_data = {DW{1'b0}};
        if (read_reg == REG_ZERO) begin
            read_data = {DW{1'b0}};
        end else if (bypass_s) begin
            read_data = write_data;
        end else begin
            read_data = regs[read_reg];
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: 32 GPRs, $zero hardwired, two bypassed read
// ports for ID, one unbypassed debug port and registered write statistics.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] DbgReg,
    output logic [DATA_W-1:0] DbgData,
    output logic              LastWrValid,
    output logic [ADDR_W-1:0] LastWrReg,
    output logic [15:0]       WrCount
);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic              wr_en_s;
    logic              last_valid_r;
    logic [ADDR_W-1:0] last_reg_r;
    logic [15:0]       wr_cnt_r;
    logic [DATA_W-1:0] dbg_data_s;

    // A write is effective only for a nonzero destination outside reset.
    always_comb begin
        wr_en_s = 1'b0;
        if (RegWrite && (WriteReg != REG_ZERO) && !reset) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage: reset clears every register and wins over a colliding write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[WriteReg] <= WriteData;
        end
    end

    // Last-write status and effective-write counter (wraps at 16 bits).
    always_ff @(posedge clk) begin
        if (reset) begin
            last_valid_r <= 1'b0;
            last_reg_r   <= {ADDR_W{1'b0}};
            wr_cnt_r     <= 16'd0;
        end else if (wr_en_s) begin
            last_valid_r <= 1'b1;
            last_reg_r   <= WriteReg;
            wr_cnt_r     <= wr_cnt_r + 16'd1;
        end
    end

    // Debug read sees committed state only, never the bypass.
    always_comb begin
        dbg_data_s = {DATA_W{1'b0}};
        if (DbgReg == REG_ZERO) begin
            dbg_data_s = {DATA_W{1'b0}};
        end else begin
            dbg_data_s = regs_r[DbgReg];
        end
    end

    rf_read_port #(.DW(DATA_W), .AW(ADDR_W), .NREGS(DEPTH)) u_port_rs (
        .read_reg   (ReadReg1),
        .regs       (regs_r),
        .reg_write  (RegWrite),
        .write_reg  (WriteReg),
        .write_data (WriteData),
        .reset      (reset),
        .read_data  (ReadData1)
    );

    rf_read_port #(.DW(DATA_W), .AW(ADDR_W), .NREGS(DEPTH)) u_port_rt (
        .read_reg   (ReadReg2),
        .regs       (regs_r),
        .reg_write  (RegWrite),
        .write_reg  (WriteReg),
        .write_data (WriteData),
        .reset      (reset),
        .read_data  (ReadData2)
    );

    assign DbgData     = dbg_data_s;
    assign LastWrValid = last_valid_r;
    assign LastWrReg   = last_reg_r;
    assign WrCount     = wr_cnt_r;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized
// traffic compared against an array-based model of the register file.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  DbgReg;
    logic [31:0] DbgData;
    logic        LastWrValid;
    logic [4:0]  LastWrReg;
    logic [15:0] WrCount;

    int checks;
    int passes;

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [4:0]  m_last;
    int          m_cnt;

    reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2),
        .DbgReg     (DbgReg),
        .DbgData    (DbgData),
        .LastWrValid(LastWrValid),
        .LastWrReg  (LastWrReg),
        .WrCount    (WrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value ID should see for an index given the current WB inputs.
    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (RegWrite && WriteReg == idx && !reset) return WriteData;
        return m_regs[idx];
    endfunction

    // Advance one clock edge, applying the architectural effect to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_valid = 1'b0;
            m_last  = 5'd0;
            m_cnt   = 0;
        end else if (RegWrite && WriteReg != 5'd0) begin
            m_regs[WriteReg] = WriteData;
            m_valid = 1'b1;
            m_last  = WriteReg;
            m_cnt   = (m_cnt + 1) % 65536;
        end
        #1;
    endtask

    task automatic do_write(input logic [4:0] r, input logic [31:0] d);
        RegWrite = 1'b1; WriteReg = r; WriteData = d;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); reset = 1'b0;
        do_write(5'd5, 32'hDEADBEEF);
        reset = 1'b1; tick(); reset = 1'b0;
        ReadReg1 = 5'd5; ReadReg2 = 5'd5; DbgReg = 5'd5; #2;
        checks++; if (ReadData1 !== 32'd0) $display("FAIL reset_rd1: got %h expected %h", ReadData1, 32'd0); else passes++;
        checks++; if (DbgData !== 32'd0) $display("FAIL reset_dbg: got %h expected %h", DbgData, 32'd0); else passes++;
        checks++; if (WrCount !== 16'd0) $display("FAIL reset_cnt: got %h expected %h", WrCount, 16'd0); else passes++;
        checks++; if (LastWrValid !== 1'b0) $display("FAIL reset_valid: got %b expected %b", LastWrValid, 1'b0); else passes++;
        checks++; if (LastWrReg !== 5'd0) $display("FAIL reset_lastreg: got %0d expected %0d", LastWrReg, 0); else passes++;
    endtask

    task automatic test_basic();
        do_write(5'd8, 32'h12345678);
        ReadReg1 = 5'd8; ReadReg2 = 5'd8; #2;
        checks++; if (ReadData1 !== 32'h12345678) $display("FAIL basic_rd1: got %h expected %h", ReadData1, 32'h12345678); else passes++;
        checks++; if (ReadData2 !== 32'h12345678) $display("FAIL basic_rd2: got %h expected %h", ReadData2, 32'h12345678); else passes++;
        checks++; if (LastWrReg !== 5'd8) $display("FAIL basic_lastreg: got %0d expected %0d", LastWrReg, 8); else passes++;
        checks++; if (WrCount !== 16'd1) $display("FAIL basic_cnt: got %0d expected %0d", WrCount, 1); else passes++;
        checks++; if (LastWrValid !== 1'b1) $display("FAIL basic_valid: got %b expected %b", LastWrValid, 1'b1); else passes++;
    endtask

    task automatic test_bypass();
        do_write(5'd9, 32'h00000001);
        RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'hAAAA0000;
        ReadReg2 = 5'd9; ReadReg1 = 5'd8; DbgReg = 5'd9; #2;
        checks++; if (ReadData2 !== 32'hAAAA0000) $display("FAIL bypass_rd2: got %h expected %h", ReadData2, 32'hAAAA0000); else passes++;
        checks++; if (ReadData1 !== 32'h12345678) $display("FAIL bypass_other_port: got %h expected %h", ReadData1, 32'h12345678); else passes++;
        checks++; if (DbgData !== 32'h00000001) $display("FAIL bypass_dbg_before: got %h expected %h", DbgData, 32'h1); else passes++;
        tick(); RegWrite = 1'b0; #2;
        checks++; if (DbgData !== 32'hAAAA0000) $display("FAIL bypass_dbg_after: got %h expected %h", DbgData, 32'hAAAA0000); else passes++;
    endtask

    task automatic test_zero();
        logic [15:0] cnt0;
        logic [4:0]  last0;
        cnt0 = WrCount; last0 = LastWrReg;
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF; ReadReg1 = 5'd0; DbgReg = 5'd0; #2;
        checks++; if (ReadData1 !== 32'd0) $display("FAIL zero_rd1_same: got %h expected %h", ReadData1, 32'd0); else passes++;
        tick(); RegWrite = 1'b0; #2;
        checks++; if (ReadData1 !== 32'd0) $display("FAIL zero_rd1_after: got %h expected %h", ReadData1, 32'd0); else passes++;
        checks++; if (DbgData !== 32'd0) $display("FAIL zero_dbg: got %h expected %h", DbgData, 32'd0); else passes++;
        checks++; if (WrCount !== cnt0) $display("FAIL zero_cnt: got %0d expected %0d", WrCount, cnt0); else passes++;
        checks++; if (LastWrReg !== last0) $display("FAIL zero_lastreg: got %0d expected %0d", LastWrReg, last0); else passes++;
    endtask

    task automatic test_reset_collision();
        do_write(5'd3, 32'h00000077);
        reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h00000055;
        ReadReg1 = 5'd3; ReadReg2 = 5'd3; #2;
        checks++; if (ReadData1 !== 32'h00000077) $display("FAIL coll_rd1_during: got %h expected %h", ReadData1, 32'h77); else passes++;
        checks++; if (ReadData2 !== 32'h00000077) $display("FAIL coll_rd2_during: got %h expected %h", ReadData2, 32'h77); else passes++;
        tick(); reset = 1'b0; RegWrite = 1'b0; DbgReg = 5'd3; #2;
        checks++; if (ReadData1 !== 32'd0) $display("FAIL coll_rd1_after: got %h expected %h", ReadData1, 32'd0); else passes++;
        checks++; if (DbgData !== 32'd0) $display("FAIL coll_dbg_after: got %h expected %h", DbgData, 32'd0); else passes++;
        checks++; if (WrCount !== 16'd0) $display("FAIL coll_cnt: got %0d expected %0d", WrCount, 0); else passes++;
        // Writes resume on the very next edge
        do_write(5'd3, 32'h00000066); #2;
        checks++; if (ReadData1 !== 32'h00000066) $display("FAIL coll_resume: got %h expected %h", ReadData1, 32'h66); else passes++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 31) == 0);
            RegWrite  = $urandom_range(0, 1);
            WriteReg  = 5'($urandom_range(0, 31));
            WriteData = $urandom;
            ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
            ReadReg2  = ($urandom_range(0, 3) == 0) ? ReadReg1 : 5'($urandom_range(0, 31));
            DbgReg    = ($urandom_range(0, 1) == 0) ? WriteReg : 5'($urandom_range(0, 31));
            #2;
            checks++; if (ReadData1 !== exp_read(ReadReg1)) begin errs++; $display("FAIL rand_rd1 r%0d: got %h expected %h", ReadReg1, ReadData1, exp_read(ReadReg1)); end else passes++;
            checks++; if (ReadData2 !== exp_read(ReadReg2)) begin errs++; $display("FAIL rand_rd2 r%0d: got %h expected %h", ReadReg2, ReadData2, exp_read(ReadReg2)); end else passes++;
            checks++; if (DbgData !== m_regs[DbgReg]) begin errs++; $display("FAIL rand_dbg r%0d: got %h expected %h", DbgReg, DbgData, m_regs[DbgReg]); end else passes++;
            tick();
            checks++;
            if (WrCount !== 16'(m_cnt) || LastWrReg !== m_last || LastWrValid !== m_valid) begin
                errs++;
                $display("FAIL rand_status: got cnt=%0d last=%0d valid=%b expected cnt=%0d last=%0d valid=%b",
                         WrCount, LastWrReg, LastWrValid, m_cnt, m_last, m_valid);
            end else passes++;
            if (errs > 20) break;
        end
        reset = 1'b0; RegWrite = 1'b0;
    endtask

    task automatic test_wrap();
        int idx;
        reset = 1'b1; tick(); reset = 1'b0;
        RegWrite = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            idx = (i % 31) + 1;
            WriteReg  = 5'(idx);
            WriteData = $urandom;
            tick();
        end
        RegWrite = 1'b0; DbgReg = 5'd2; ReadReg1 = 5'd2; #2;
        checks++; if (WrCount !== 16'h0000) $display("FAIL wrap_cnt: got %h expected %h", WrCount, 16'h0000); else passes++;
        checks++; if (LastWrReg !== 5'd2) $display("FAIL wrap_lastreg: got %0d expected %0d", LastWrReg, 2); else passes++;
        checks++; if (LastWrValid !== 1'b1) $display("FAIL wrap_valid: got %b expected %b", LastWrValid, 1'b1); else passes++;
        checks++; if (DbgData !== m_regs[2]) $display("FAIL wrap_dbg: got %h expected %h", DbgData, m_regs[2]); else passes++;
        // One more write steps the wrapped counter to 1
        do_write(5'd7, 32'h0BADF00D);
        checks++; if (WrCount !== 16'h0001) $display("FAIL wrap_plus1: got %h expected %h", WrCount, 16'h0001); else passes++;
    endtask

    initial begin
        checks = 0; passes = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0; m_last = 5'd0; m_cnt = 0;
        reset = 1'b1; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'd0;
        ReadReg1 = 5'd0; ReadReg2 = 5'd0; DbgReg = 5'd0;

        test_reset();
        test_basic();
        test_bypass();
        test_zero();
        test_reset_collision();
        test_random();
        test_wrap();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
